// File: rtl/cache_sa_wb.sv
// Set-associative (1 or 2 way) write-back / write-allocate data cache with LRU replacement.
// Hits complete combinationally; misses run an optional write-back then a line fill over a req/ack bus.

module cache_sa_wb_way #(
  parameter int SETS       = 256,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = 8,
  parameter int TAG_W      = 20,
  parameter int WSEL_W     = 2
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic [IDX_W-1:0]        idx,
  input  logic [TAG_W-1:0]        req_tag,
  input  logic [WSEL_W-1:0]       word_sel,
  input  logic                    line_we,
  input  logic [32*LINE_WORDS-1:0] fill_line,
  input  logic [TAG_W-1:0]        fill_tag,
  input  logic                    word_we,
  input  logic [31:0]             wdata,
  input  logic [3:0]              wstrb,
  output logic                    hit,
  output logic                    vld,
  output logic                    dirty,
  output logic [TAG_W-1:0]        tag,
  output logic [32*LINE_WORDS-1:0] line,
  output logic [31:0]             rword
);
  logic [SETS-1:0] valid_q, valid_d;
  logic [SETS-1:0] dirty_q, dirty_d;
  logic [LINE_WORDS-1:0][31:0] data_mem [SETS];
  logic [TAG_W-1:0]            tag_mem  [SETS];
  logic [LINE_WORDS-1:0][31:0] line_w;

  assign line_w = data_mem[idx];
  assign line   = line_w;
  assign tag    = tag_mem[idx];
  assign vld    = valid_q[idx];
  assign dirty  = dirty_q[idx];
  assign hit    = vld && (tag == req_tag);
  assign rword  = line_w[word_sel];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (line_we) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end else if (word_we) begin
      dirty_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Payload arrays carry no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_mem[idx] <= fill_line;
      tag_mem[idx]  <= fill_tag;
    end else if (word_we) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) data_mem[idx][word_sel][8*b +: 8] <= wdata[8*b +: 8];
    end
  end
endmodule

module cache_sa_wb #(
  parameter int SETS       = 256,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [31:0]              cpu_addr,
  input  logic                     cpu_read,
  input  logic                     cpu_write,
  input  logic [31:0]              cpu_wdata,
  input  logic [3:0]               cpu_wstrb,
  output logic [31:0]              cpu_rdata,
  output logic                     cpu_hit,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [32*LINE_WORDS-1:0] mem_wdata,
  input  logic [32*LINE_WORDS-1:0] mem_rdata,
  input  logic                     mem_ack,
  output logic [31:0]              stat_hits,
  output logic [31:0]              stat_misses
);
  localparam int LINE_W = 32*LINE_WORDS;
  localparam int OFF    = $clog2(4*LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - OFF - IDX_W;
  localparam int WSEL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WB   = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [0:0]        victim_q, victim_d;
  logic [TAG_W-1:0]  req_tag_q, req_tag_d;
  logic [IDX_W-1:0]  req_idx_q, req_idx_d;
  logic [SETS-1:0]   lru_q, lru_d;
  logic [31:0]       hits_q, hits_d;
  logic [31:0]       misses_q, misses_d;

  logic [IDX_W-1:0]  cpu_idx, arr_idx;
  logic [TAG_W-1:0]  cpu_tag;
  logic [WSEL_W-1:0] word_sel;
  logic              req, any_hit;
  logic [0:0]        hit_way, vic;
  logic [WAYS-1:0]   way_hit, way_vld, way_dirty, line_we, word_we;
  logic [WAYS-1:0][TAG_W-1:0]  way_tag;
  logic [WAYS-1:0][LINE_W-1:0] way_line;
  logic [WAYS-1:0][31:0]       way_rword;

  assign cpu_idx  = cpu_addr[OFF +: IDX_W];
  assign cpu_tag  = cpu_addr[31 -: TAG_W];
  assign word_sel = WSEL_W'((cpu_addr >> 2) & 32'(LINE_WORDS - 1));
  assign arr_idx  = (state_q == ST_IDLE) ? cpu_idx : req_idx_q;
  assign req      = cpu_read | cpu_write;
  assign any_hit  = |way_hit;
  assign hit_way  = (WAYS > 1) ? way_hit[WAYS-1] : 1'b0;
  assign cpu_hit  = (state_q == ST_IDLE) && req && any_hit;
  assign cpu_rdata = cpu_hit ? way_rword[hit_way] : 32'h0;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_sa_wb_way #(
      .SETS(SETS), .LINE_WORDS(LINE_WORDS), .IDX_W(IDX_W), .TAG_W(TAG_W), .WSEL_W(WSEL_W)
    ) u_way (
      .clk       (clk),
      .rst_b     (rst_b),
      .idx       (arr_idx),
      .req_tag   (cpu_tag),
      .word_sel  (word_sel),
      .line_we   (line_we[w]),
      .fill_line (mem_rdata),
      .fill_tag  (req_tag_q),
      .word_we   (word_we[w]),
      .wdata     (cpu_wdata),
      .wstrb     (cpu_wstrb),
      .hit       (way_hit[w]),
      .vld       (way_vld[w]),
      .dirty     (way_dirty[w]),
      .tag       (way_tag[w]),
      .line      (way_line[w]),
      .rword     (way_rword[w])
    );
  end

  // Victim: first invalid way, otherwise the way the set's LRU bit names.
  always_comb begin
    vic = 1'b0;
    if (WAYS > 1) begin
      if (!way_vld[0])           vic = 1'b0;
      else if (!way_vld[WAYS-1]) vic = 1'b1;
      else                       vic = lru_q[cpu_idx];
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    victim_d    = victim_q;
    req_tag_d   = req_tag_q;
    req_idx_d   = req_idx_q;
    lru_d       = lru_q;
    hits_d      = hits_q;
    misses_d    = misses_q;
    line_we     = '0;
    word_we     = '0;
    case (state_q)
      ST_IDLE: begin
        if (req && any_hit) begin
          hits_d = (hits_q == 32'hFFFF_FFFF) ? hits_q : hits_q + 32'd1;
          if (WAYS > 1) lru_d[cpu_idx] = ~hit_way;
          if (cpu_write) word_we[hit_way] = 1'b1;
        end else if (req) begin
          misses_d  = (misses_q == 32'hFFFF_FFFF) ? misses_q : misses_q + 32'd1;
          victim_d  = vic;
          req_tag_d = cpu_tag;
          req_idx_d = cpu_idx;
          mem_req_d = 1'b1;
          if (way_vld[vic] && way_dirty[vic]) begin
            state_d     = ST_WB;
            mem_we_d    = 1'b1;
            mem_addr_d  = {way_tag[vic], cpu_idx, {OFF{1'b0}}};
            mem_wdata_d = way_line[vic];
          end else begin
            state_d    = ST_FILL;
            mem_we_d   = 1'b0;
            mem_addr_d = {cpu_tag, cpu_idx, {OFF{1'b0}}};
          end
        end
      end
      ST_WB: begin
        if (mem_req_q && mem_ack) begin
          state_d    = ST_FILL;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          mem_addr_d = {req_tag_q, req_idx_q, {OFF{1'b0}}};
        end
      end
      ST_FILL: begin
        // First FILL cycle after a write-back re-raises the request.
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
        end else if (mem_ack) begin
          line_we[victim_q] = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      victim_q    <= '0;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      lru_q       <= '0;
      hits_q      <= '0;
      misses_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      victim_q    <= victim_d;
      req_tag_q   <= req_tag_d;
      req_idx_q   <= req_idx_d;
      lru_q       <= lru_d;
      hits_q      <= hits_d;
      misses_q    <= misses_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
endmodule
